// File: rtl/demux_1ton_stream.sv
// 1-to-N stream demultiplexer: one registered slot per output channel, with
// broadcast, and sticky error plus saturating drop count for out-of-range selects.
module demux_1ton_stream #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int CNT_W = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic               i_bcast,
    input  logic               i_valid,
    output logic               i_ready,
    output logic [N*WIDTH-1:0] o_data,
    output logic [N-1:0]       o_valid,
    input  logic [N-1:0]       o_ready,
    output logic               err_sel,
    output logic [CNT_W-1:0]   drop_cnt
);

    logic [N-1:0]     valid_r;
    logic [WIDTH-1:0] data_r [N];
    logic             err_sel_r;
    logic [CNT_W-1:0] drop_cnt_r;

    logic [N-1:0]     can_take_s;
    logic [N-1:0]     push_s;
    logic             sel_in_range_s;
    logic             ready_s;
    logic             drop_s;

    // A slot can take a word when it is empty or is being drained this cycle.
    always_comb begin
        can_take_s = ~valid_r | o_ready;
    end

    // Readiness, push targets and out-of-range sinking.
    always_comb begin
        sel_in_range_s = (int'(i_sel) < N);
        ready_s        = 1'b1;
        push_s         = '0;
        drop_s         = 1'b0;
        if (i_bcast) begin
            // All slots load together or none do.
            ready_s = &can_take_s;
            if (i_valid && ready_s) begin
                push_s = '1;
            end else begin
                push_s = '0;
            end
        end else if (sel_in_range_s) begin
            ready_s        = can_take_s[i_sel];
            push_s[i_sel]  = i_valid & ready_s;
        end else begin
            ready_s = 1'b1;
            drop_s  = i_valid;
        end
    end

    // Per-channel slot update; a push in the same cycle as a pop keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int k = 0; k < N; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (push_s[k]) begin
                    valid_r[k] <= 1'b1;
                    data_r[k]  <= i_data;
                end else if (valid_r[k] && o_ready[k]) begin
                    valid_r[k] <= 1'b0;
                end
            end
        end
    end

    // Drop accounting: sticky flag and saturating counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sel_r  <= 1'b0;
            drop_cnt_r <= '0;
        end else if (drop_s) begin
            err_sel_r <= 1'b1;
            if (drop_cnt_r != {CNT_W{1'b1}}) begin
                drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign o_data[k*WIDTH +: WIDTH] = data_r[k];
    end

    assign o_valid  = valid_r;
    assign i_ready  = ready_s;
    assign err_sel  = err_sel_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Self-checking bench: vector table and corner sequences on N=4 and N=3 instances,
// then a randomised per-channel queue scoreboard.
module tb_demux_1ton_stream;

    logic        clk;
    logic        rst;

    logic [7:0]  d4_data;
    logic [1:0]  d4_sel;
    logic        d4_bcast, d4_valid, d4_ready, d4_err;
    logic [31:0] d4_odata;
    logic [3:0]  d4_ovalid, d4_oready;
    logic [7:0]  d4_drop;

    logic [7:0]  d3_data;
    logic [1:0]  d3_sel;
    logic        d3_bcast, d3_valid, d3_ready, d3_err;
    logic [23:0] d3_odata;
    logic [2:0]  d3_ovalid, d3_oready;
    logic [7:0]  d3_drop;

    int vectors = 0;
    int miscompares = 0;

    demux_1ton_stream #(.WIDTH(8), .N(4), .CNT_W(8)) u_d4 (
        .clk(clk), .rst(rst), .i_data(d4_data), .i_sel(d4_sel), .i_bcast(d4_bcast),
        .i_valid(d4_valid), .i_ready(d4_ready), .o_data(d4_odata), .o_valid(d4_ovalid),
        .o_ready(d4_oready), .err_sel(d4_err), .drop_cnt(d4_drop)
    );

    demux_1ton_stream #(.WIDTH(8), .N(3), .CNT_W(8)) u_d3 (
        .clk(clk), .rst(rst), .i_data(d3_data), .i_sel(d3_sel), .i_bcast(d3_bcast),
        .i_valid(d3_valid), .i_ready(d3_ready), .o_data(d3_odata), .o_valid(d3_ovalid),
        .o_ready(d3_oready), .err_sel(d3_err), .drop_cnt(d3_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  sel;
        logic        bcast;
        logic        valid;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic [7:0] data, logic [1:0] sel, logic bcast, logic valid,
                                 logic [3:0] ordy, logic exp_rdy, logic [3:0] exp_ov,
                                 logic [31:0] exp_od);
        vec_t v;
        v.data = data; v.sel = sel; v.bcast = bcast; v.valid = valid; v.ordy = ordy;
        v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_od = exp_od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the random phase: one queue of pending words per channel.
    logic [7:0] q [4][$];

    initial begin
        rst = 1'b1;
        d4_data = 8'h00; d4_sel = 2'd0; d4_bcast = 1'b0; d4_valid = 1'b0; d4_oready = 4'b0000;
        d3_data = 8'h00; d3_sel = 2'd0; d3_bcast = 1'b0; d3_valid = 1'b0; d3_oready = 3'b000;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_d4_ovalid", 64'(d4_ovalid), 64'h0);
        chk("rst_d4_odata",  64'(d4_odata),  64'h0);
        chk("rst_d3_err",    64'(d3_err),    64'h0);
        chk("rst_d3_drop",   64'(d3_drop),   64'h0);

        // Routing, backpressure and broadcast table on the N=4 instance.
        vecs.push_back(mkv(8'hA0, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h000000A0));
        vecs.push_back(mkv(8'hB0, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h0000B0A0));
        vecs.push_back(mkv(8'hC0, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00C0B0A0));
        vecs.push_back(mkv(8'hD0, 2'd3, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'hD0C0B0A0));
        vecs.push_back(mkv(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'hD0C0B0A0));
        vecs.push_back(mkv(8'h11, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 32'hD0C011A0));
        vecs.push_back(mkv(8'h22, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'hD0C011A0));
        vecs.push_back(mkv(8'h33, 2'd0, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0011, 32'hD0C01133));
        vecs.push_back(mkv(8'h22, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'hD0C02233));
        vecs.push_back(mkv(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'hD0C02233));
        vecs.push_back(mkv(8'h5A, 2'd2, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 32'h5A5A5A5A));
        vecs.push_back(mkv(8'h00, 2'd0, 1'b0, 1'b0, 4'b0111, 1'b1, 4'b1000, 32'h5A5A5A5A));
        vecs.push_back(mkv(8'h77, 2'd0, 1'b1, 1'b1, 4'b0111, 1'b0, 4'b1000, 32'h5A5A5A5A));
        vecs.push_back(mkv(8'h00, 2'd3, 1'b0, 1'b0, 4'b0111, 1'b0, 4'b1000, 32'h5A5A5A5A));
        vecs.push_back(mkv(8'h88, 2'd1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111, 32'h88888888));
        vecs.push_back(mkv(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h88888888));

        foreach (vecs[i]) begin
            d4_data = vecs[i].data; d4_sel = vecs[i].sel; d4_bcast = vecs[i].bcast;
            d4_valid = vecs[i].valid; d4_oready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_i_ready", i), 64'(d4_ready), 64'(vecs[i].exp_rdy));
            tick();
            chk($sformatf("vec%0d_o_valid", i), 64'(d4_ovalid), 64'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_o_data", i),  64'(d4_odata),  64'(vecs[i].exp_od));
        end
        d4_valid = 1'b0;

        // Out-of-range and highest in-range select on the N=3 instance.
        d3_oready = 3'b111;
        d3_sel = 2'd3; d3_data = 8'hEE; d3_valid = 1'b1;
        #1;
        chk("oor_i_ready", 64'(d3_ready), 64'h1);
        tick();
        d3_valid = 1'b0;
        chk("oor_o_valid", 64'(d3_ovalid), 64'h0);
        chk("oor_err",     64'(d3_err),    64'h1);
        chk("oor_drop",    64'(d3_drop),   64'h1);
        d3_sel = 2'd2; d3_data = 8'h42; d3_valid = 1'b1;
        #1;
        chk("sel2_i_ready", 64'(d3_ready), 64'h1);
        tick();
        d3_valid = 1'b0;
        chk("sel2_o_valid", 64'(d3_ovalid), 64'h4);
        chk("sel2_o_data",  64'(d3_odata[23:16]), 64'h42);
        chk("sel2_drop",    64'(d3_drop), 64'h1);
        d3_sel = 2'd3; d3_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            d3_data = 8'($urandom);
            tick();
            if (i == 252) chk("drop_254", 64'(d3_drop), 64'd254);
        end
        d3_valid = 1'b0;
        chk("drop_sat",     64'(d3_drop),   64'hFF);
        chk("drop_sat_err", 64'(d3_err),    64'h1);
        chk("drop_sat_ov",  64'(d3_ovalid), 64'h0);

        // Reset in the middle of operation; the word offered during reset is not stored.
        d4_oready = 4'b0000; d4_bcast = 1'b0; d4_valid = 1'b1;
        d4_sel = 2'd0; d4_data = 8'h12; tick();
        d4_sel = 2'd2; d4_data = 8'h34; tick();
        chk("mid_o_valid", 64'(d4_ovalid), 64'h5);
        chk("mid_o_data",  64'(d4_odata),  64'h88348812);
        rst = 1'b1; d4_sel = 2'd1; d4_data = 8'h99;
        tick();
        rst = 1'b0; d4_valid = 1'b0;
        chk("rst2_o_valid", 64'(d4_ovalid), 64'h0);
        chk("rst2_o_data",  64'(d4_odata),  64'h0);
        chk("rst2_d3_err",  64'(d3_err),    64'h0);
        chk("rst2_d3_drop", 64'(d3_drop),   64'h0);
        tick();
        chk("rst3_o_valid", 64'(d4_ovalid), 64'h0);
        chk("rst3_o_data",  64'(d4_odata),  64'h0);

        // Randomised traffic against per-channel queues.
        for (int c = 0; c < 10000; c++) begin
            logic       exp_rdy;
            logic [3:0] exp_ov;
            logic [31:0] exp_od, mask;
            d4_data   = 8'($urandom);
            d4_sel    = 2'($urandom_range(0, 3));
            d4_bcast  = ($urandom_range(0, 7) == 0);
            d4_valid  = ($urandom_range(0, 3) != 0);
            d4_oready = 4'($urandom);
            #1;
            exp_rdy = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (d4_bcast || int'(d4_sel) == k) begin
                    if (q[k].size() != 0 && !d4_oready[k]) exp_rdy = 1'b0;
                end
            end
            chk("rand_i_ready", 64'(d4_ready), 64'(exp_rdy));
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && d4_oready[k]) void'(q[k].pop_front());
            end
            if (d4_valid && exp_rdy) begin
                for (int k = 0; k < 4; k++) begin
                    if (d4_bcast || int'(d4_sel) == k) q[k].push_back(d4_data);
                end
            end
            tick();
            exp_ov = 4'b0000; exp_od = 32'h0; mask = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0) begin
                    exp_ov[k] = 1'b1;
                    exp_od[k*8 +: 8] = q[k][0];
                    mask[k*8 +: 8] = 8'hFF;
                end
            end
            chk("rand_o_valid", 64'(d4_ovalid), 64'(exp_ov));
            chk("rand_o_data",  64'(d4_odata & mask), 64'(exp_od));
        end
        d4_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
